// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t   : loader FSM state encoding (3 bits)
//   LEN_BYTES : number of little-endian length bytes that prefix an image
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam int unsigned LEN_BYTES = 4;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer.
//   clk, rst_n : clock, async active-low reset
//   en         : write data into lane of the word buffer this cycle
//   lane       : byte lane (0 = bits 7:0)
//   data       : byte to place
//   word_c     : buffered word with the current byte already merged in, so
//                the consumer sees the complete word on the cycle the last
//                byte arrives
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        lane,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word_c
);

  logic [WORD_W-1:0] word;

  // Merge the incoming byte into its lane
  always_comb begin
    word_c = word;
    case (lane)
      2'd0:    word_c[7:0]   = data;
      2'd1:    word_c[15:8]  = data;
      2'd2:    word_c[23:16] = data;
      default: word_c[31:24] = data;
    endcase
  end

  // Lanes hold their value while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else if (en) begin
      word <= word_c;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Accepts a byte stream {N[31:0] LE, N*4 payload bytes, xor checksum} and
// writes the payload words to word addresses 0..N-1, holding the core in
// stall until the image verifies.
//   clk, rst_n        : clock, async active-low reset
//   start             : pulse; begins a load from IDLE, DONE or ERROR
//   in_valid/in_data  : byte stream input, in_ready : byte accepted
//   mem_wn            : one-cycle write strobe per assembled word
//   mem_address       : word address of the write
//   mem_write_data    : word written
//   core_hold         : fetch stall, busy : load in progress
//   done / error      : sticky completion / failure flags
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_wn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_write_data,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] n_words;
  logic [BYTE_W-1:0] csum;

  logic              xfer_c;
  logic              pack_en_c;
  logic              last_lane_c;
  logic [ADDR_W-1:0] word_cnt_inc_c;
  logic [WORD_W-1:0] word_c;

  assign xfer_c         = in_valid & in_ready;
  assign pack_en_c      = xfer_c & ((state == S_LEN) | (state == S_DATA));
  assign last_lane_c    = (byte_cnt == 2'(LEN_BYTES - 1));
  assign word_cnt_inc_c = word_cnt + ADDR_W'(1);

  // Shared by the length field and the payload words
  byte_packer u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (pack_en_c),
    .lane   (byte_cnt),
    .data   (in_data),
    .word_c (word_c)
  );

  // Loader FSM, counters and checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      in_ready       <= 1'b0;
      mem_wn         <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      core_hold      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      byte_cnt       <= '0;
      word_cnt       <= '0;
      n_words        <= '0;
      csum           <= '0;
    end else begin
      mem_wn <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state     <= S_LEN;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            csum      <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b1;
            core_hold <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        S_LEN: begin
          if (xfer_c) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (last_lane_c) begin
              if (word_c > WORD_W'(DEPTH_WORDS)) begin
                state    <= S_ERROR;
                error    <= 1'b1;
                busy     <= 1'b0;
                in_ready <= 1'b0;
              end else if (word_c == '0) begin
                state <= S_CSUM;
              end else begin
                state   <= S_DATA;
                n_words <= ADDR_W'(word_c);
              end
            end
          end
        end
        S_DATA: begin
          if (xfer_c) begin
            byte_cnt <= byte_cnt + 2'd1;
            csum     <= csum ^ in_data;
            if (last_lane_c) begin
              mem_wn         <= 1'b1;
              mem_address    <= word_cnt;
              mem_write_data <= word_c;
              word_cnt       <= word_cnt_inc_c;
              if (word_cnt_inc_c == n_words) begin
                state <= S_CSUM;
              end
            end
          end
        end
        S_CSUM: begin
          if (xfer_c) begin
            busy     <= 1'b0;
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
